oled_spi_rx: RTL and testbench
==============================

Name: oled_spi_rx

Overview:
- Receiver for the serial PmodOLEDrgb link that the OLED display driver produces on JC (cs, sdin, sclk, d_cn, resn, vccen, pmoden).
- Oversamples the link on the 100 MHz system clock and deserialises it into command bytes and RGB565 pixels.
- Tags each pixel with its frame index and x/y coordinate.
- Used for loopback verification of the display path and for mirroring the fight screen onto a second board.

Parameters:
- WIDTH, 96, panel columns
- HEIGHT, 64, panel rows
- SYNC_STAGES, 2, synchroniser flops on each JC input (minimum 2)

Ports:
- clk  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-low reset
- cs  in  1  chip select from link, active-low
- sdin  in  1  serial data, MSB first
- sclk  in  1  serial clock; data valid on rising edge
- d_cn  in  1  0 = command byte, 1 = data byte
- resn  in  1  panel reset line
- vccen  in  1  panel VCC enable
- pmoden  in  1  Pmod power enable
- byte_valid  out  1  one-cycle pulse per completed byte
- byte_data  out  8  completed byte
- byte_is_data  out  1  d_cn captured with bit 0 of that byte
- pixel_valid  out  1  one-cycle pulse per completed 16-bit pixel
- pixel_data  out  16  RGB565 pixel, first byte in [15:8]
- pixel_index  out  13  0..WIDTH*HEIGHT-1 for the pixel on pixel_data
- pixel_x  out  7  column of pixel_index
- pixel_y  out  6  row of pixel_index
- frame_start  out  1  pulses with pixel_valid when pixel_index == 0
- frame_count  out  8  completed frames, wraps 255 -> 0
- panel_on  out  1  synchronised resn & vccen & pmoden

Behaviour:
- Reset (reset low, asynchronous): all outputs 0; shift register, bit counter, byte phase, pixel index, x, y and frame counter cleared.
- Input conditioning:
  - Every JC input passes through SYNC_STAGES flops.
  - sclk rising edge = synchronised sclk is 1 now and was 0 one cycle earlier.
  - Link requirement: sclk high and low phases each ≥ 2 clk periods.
- Bit capture: on a rising edge with synchronised cs == 0, shift sdin into the LSB and increment the 3-bit bit counter.
- Byte completion:
  - On the 8th bit, capture d_cn with that bit.
  - In the next clk cycle assert byte_valid for exactly 1 cycle, with byte_data and byte_is_data stable during the pulse.
  - Latency from raw sclk edge to byte_valid: SYNC_STAGES + 2 cycles.
- cs handling:
  - cs high at any time clears the bit counter; a partial byte is discarded with no pulse.
  - Byte phase and pixel index are kept across cs high.
- Pixel assembly (state machine: IDLE, HAVE_HI):
  - IDLE + data byte: store byte as high half, go to HAVE_HI.
  - HAVE_HI + data byte: form pixel from stored high byte and this byte, pulse pixel_valid, go to IDLE.
  - pixel_valid is coincident with byte_valid of the second byte.
  - Any command byte: go to IDLE; pixel_index, x and y = 0; no pixel_valid. The command byte itself still produces byte_valid.
- Index and coordinates:
  - After each pixel_valid, pixel_index increments; x increments and wraps at WIDTH-1 -> 0, incrementing y.
  - At index WIDTH*HEIGHT-1 (6143 at defaults): next index 0, x = y = 0, frame_count += 1.
  - Coordinates come from the x/y counters, never from a divider.
- frame_start: asserted together with pixel_valid whenever that pixel's index is 0, including the first frame after reset or after a command.
- panel_on: registered AND of the synchronised resn, vccen and pmoden; it does not gate decoding.
- Reset mid-byte: the partial byte is lost and the next byte starts from bit 7 on the first edge after reset release with cs low.

Decomposition:
- Package oled_pkg:
  - OLED_WIDTH = 96, OLED_HEIGHT = 64
  - OLED_NUM_PIXELS = 6144
  - OLED_IDX_W = 13, OLED_X_W = 7, OLED_Y_W = 6
  - RGB565 field positions: R [15:11], G [10:5], B [4:0]
- Sub-module spi_byte_shifter: synchronisers, sclk edge detect, cs abort, 8-bit shift and byte_valid/byte_is_data generation.
- oled_spi_rx: pixel state machine, index/x/y/frame counters and panel_on.

Test Plan:
- Command then 2 data bytes: cs low; send 0xA0 with d_cn=0, then 0xF8, 0x00 with d_cn=1 -> byte_valid pulses 3 times with byte_is_data 0,1,1; one pixel_valid with pixel_data=16'hF800, pixel_index=0, x=0, y=0, frame_start=1.
- Row wrap: 97 pixels of 16'h07E0 -> pixel 96 has pixel_index=96, x=0, y=1; pixel 95 has x=95, y=0.
- Full frame wrap: 6145 pixels -> pixel 6143 has x=95, y=63; pixel 6144 has pixel_index=0, frame_start=1; frame_count=1.
- cs abort: 5 bits of 0xFF, cs high 10 cycles, cs low, then 0x12 -> exactly one byte_valid, byte_data=0x12.
- Mid-pixel command: data 0xAB, command 0x15, data 0x12, 0x34 -> no pixel containing 0xAB; one pixel 16'h1234 at index 0.
- Asynchronous reset after 3 pixels (reset low 2 cycles) -> all outputs 0 immediately; next pixel 16'h001F reports index 0 and frame_start=1; panel_on follows resn & vccen & pmoden within SYNC_STAGES+1 cycles.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared geometry, pixel format and state types for the PmodOLEDrgb link receiver.
package oled_pkg;

  localparam int OLED_WIDTH      = 96;
  localparam int OLED_HEIGHT     = 64;
  localparam int OLED_NUM_PIXELS = OLED_WIDTH * OLED_HEIGHT;

  localparam int OLED_IDX_W = 13;
  localparam int OLED_X_W   = 7;
  localparam int OLED_Y_W   = 6;

  localparam int RGB_R_MSB = 15;
  localparam int RGB_R_LSB = 11;
  localparam int RGB_G_MSB = 10;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_MSB = 4;
  localparam int RGB_B_LSB = 0;

  typedef struct packed {
    logic [RGB_R_MSB-RGB_R_LSB:0] r;
    logic [RGB_G_MSB-RGB_G_LSB:0] g;
    logic [RGB_B_MSB-RGB_B_LSB:0] b;
  } rgb565_t;

  typedef enum logic {
    PIX_IDLE    = 1'b0,
    PIX_HAVE_HI = 1'b1
  } pix_state_t;

  // The panel receives the high byte first, so it lands in r and the top of g.
  function automatic rgb565_t pack_rgb565(input logic [7:0] hi, input logic [7:0] lo);
    return rgb565_t'({hi, lo});
  endfunction

endpackage

// File: rtl/oled_spi_rx_if.sv
// Link inputs from the JC header plus the decoded byte/pixel stream of the receiver.
interface oled_spi_rx_if;

  logic cs;
  logic sdin;
  logic sclk;
  logic d_cn;
  logic resn;
  logic vccen;
  logic pmoden;

  logic                            byte_valid;
  logic [7:0]                      byte_data;
  logic                            byte_is_data;
  logic                            pixel_valid;
  logic [15:0]                     pixel_data;
  logic [oled_pkg::OLED_IDX_W-1:0] pixel_index;
  logic [oled_pkg::OLED_X_W-1:0]   pixel_x;
  logic [oled_pkg::OLED_Y_W-1:0]   pixel_y;
  logic                            frame_start;
  logic [7:0]                      frame_count;
  logic                            panel_on;

  modport master (
    output cs, sdin, sclk, d_cn, resn, vccen, pmoden,
    input  byte_valid, byte_data, byte_is_data, pixel_valid, pixel_data,
           pixel_index, pixel_x, pixel_y, frame_start, frame_count, panel_on
  );

  modport slave (
    input  cs, sdin, sclk, d_cn, resn, vccen, pmoden,
    output byte_valid, byte_data, byte_is_data, pixel_valid, pixel_data,
           pixel_index, pixel_x, pixel_y, frame_start, frame_count, panel_on
  );

endinterface

// File: rtl/spi_byte_shifter.sv
// Synchronises the JC inputs, detects sclk rising edges and shifts MSB-first bytes.
// byte_valid rises SYNC_STAGES+2 cycles after the raw sclk edge of bit 0; cs high drops a partial byte.
module spi_byte_shifter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       sdin,
  input  logic       sclk,
  input  logic       d_cn,
  input  logic       resn,
  input  logic       vccen,
  input  logic       pmoden,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_is_data,
  output logic       power_ok
);

  // cs and sclk come out of reset high so a released link never looks like an active edge.
  localparam logic [6:0] SYNC_RST = 7'b1100000;

  logic [6:0] raw;
  logic [6:0] sync_q [SYNC_STAGES];
  logic [6:0] synced;

  logic       cs_s;
  logic       sclk_s;
  logic       sdin_s;
  logic       d_cn_s;
  logic       sclk_q;
  logic       rise;

  logic [7:0] shift_q;
  logic [2:0] bit_cnt;
  logic       done_q;
  logic       dc_q;

  assign raw = {cs, sclk, sdin, d_cn, resn, vccen, pmoden};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= SYNC_RST;
      end
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign synced   = sync_q[SYNC_STAGES-1];
  assign cs_s     = synced[6];
  assign sclk_s   = synced[5];
  assign sdin_s   = synced[4];
  assign d_cn_s   = synced[3];
  assign power_ok = &synced[2:0];

  assign rise = sclk_s & ~sclk_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_q       <= 1'b1;
      shift_q      <= 8'h00;
      bit_cnt      <= 3'd0;
      done_q       <= 1'b0;
      dc_q         <= 1'b0;
      byte_valid   <= 1'b0;
      byte_data    <= 8'h00;
      byte_is_data <= 1'b0;
    end else begin
      sclk_q <= sclk_s;
      done_q <= 1'b0;
      if (cs_s) begin
        bit_cnt <= 3'd0;
      end else if (rise) begin
        shift_q <= {shift_q[6:0], sdin_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          done_q <= 1'b1;
          dc_q   <= d_cn_s;
        end
      end
      byte_valid <= done_q;
      if (done_q) begin
        byte_data    <= shift_q;
        byte_is_data <= dc_q;
      end
    end
  end

endmodule

// File: rtl/oled_spi_rx.sv
// PmodOLEDrgb link receiver: pairs data bytes into RGB565 pixels tagged with index, x/y and frame.
// pixel_valid coincides with the second byte's byte_valid; commands rewind the pixel position.
module oled_spi_rx
  import oled_pkg::*;
#(
  parameter int WIDTH       = OLED_WIDTH,
  parameter int HEIGHT      = OLED_HEIGHT,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  oled_spi_rx_if.slave  bus
);

  localparam int NUM_PIXELS = WIDTH * HEIGHT;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_is_data;
  logic       power_ok;

  pix_state_t            state_q, state_d;
  logic [7:0]            hi_q, hi_d;
  logic [OLED_IDX_W-1:0] idx_q, idx_d;
  logic [OLED_X_W-1:0]   x_q, x_d;
  logic [OLED_Y_W-1:0]   y_q, y_d;
  logic [7:0]            frame_q, frame_d;
  logic                  pix_fire;
  logic                  panel_on_q;

  spi_byte_shifter #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_shifter (
    .clk          (clk),
    .reset        (reset),
    .cs           (bus.cs),
    .sdin         (bus.sdin),
    .sclk         (bus.sclk),
    .d_cn         (bus.d_cn),
    .resn         (bus.resn),
    .vccen        (bus.vccen),
    .pmoden       (bus.pmoden),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_is_data (byte_is_data),
    .power_ok     (power_ok)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= PIX_IDLE;
      hi_q       <= 8'h00;
      idx_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      frame_q    <= 8'h00;
      panel_on_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      idx_q      <= idx_d;
      x_q        <= x_d;
      y_q        <= y_d;
      frame_q    <= frame_d;
      panel_on_q <= power_ok;
    end
  end

  // x/y run alongside the linear index so no divider is needed for coordinates.
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    idx_d    = idx_q;
    x_d      = x_q;
    y_d      = y_q;
    frame_d  = frame_q;
    pix_fire = 1'b0;
    if (byte_valid) begin
      if (!byte_is_data) begin
        state_d = PIX_IDLE;
        idx_d   = '0;
        x_d     = '0;
        y_d     = '0;
      end else if (state_q == PIX_IDLE) begin
        hi_d    = byte_data;
        state_d = PIX_HAVE_HI;
      end else begin
        pix_fire = 1'b1;
        state_d  = PIX_IDLE;
        if (idx_q == OLED_IDX_W'(NUM_PIXELS - 1)) begin
          idx_d   = '0;
          x_d     = '0;
          y_d     = '0;
          frame_d = frame_q + 8'd1;
        end else begin
          idx_d = idx_q + OLED_IDX_W'(1);
          if (x_q == OLED_X_W'(WIDTH - 1)) begin
            x_d = '0;
            y_d = y_q + OLED_Y_W'(1);
          end else begin
            x_d = x_q + OLED_X_W'(1);
          end
        end
      end
    end
  end

  assign bus.byte_valid   = byte_valid;
  assign bus.byte_data    = byte_data;
  assign bus.byte_is_data = byte_is_data;
  assign bus.pixel_valid  = pix_fire;
  assign bus.pixel_data   = pack_rgb565(hi_q, byte_data);
  assign bus.pixel_index  = idx_q;
  assign bus.pixel_x      = x_q;
  assign bus.pixel_y      = y_q;
  assign bus.frame_start  = pix_fire & (idx_q == '0);
  assign bus.frame_count  = frame_q;
  assign bus.panel_on     = panel_on_q;

endmodule

// File: tb/tb_oled_spi_rx.sv
// Scoreboard bench for oled_spi_rx on a 16x4 panel so a full frame wrap stays short.
module tb_oled_spi_rx;

  localparam int W    = 16;
  localparam int H    = 4;
  localparam int S    = 2;
  localparam int NPIX = W * H;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  oled_spi_rx_if bus();

  oled_spi_rx #(
    .WIDTH       (W),
    .HEIGHT      (H),
    .SYNC_STAGES (S)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] d;
    logic       dc;
  } exp_byte_t;

  typedef struct {
    logic [15:0] d;
    int          idx;
    int          x;
    int          y;
    logic        fs;
    int          fc;
  } exp_pix_t;

  exp_byte_t bq[$];
  exp_pix_t  pq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_rise = 0;

  logic       have_hi;
  logic [7:0] m_hi;
  int         m_idx;
  int         m_frame;
  logic       prev_bv;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // Reference model: what the receiver should report for each byte sent.
  task automatic model_byte(input logic [7:0] b, input logic dc);
    exp_pix_t p;
    bq.push_back('{d: b, dc: dc});
    if (!dc) begin
      have_hi = 1'b0;
      m_idx   = 0;
    end else if (!have_hi) begin
      have_hi = 1'b1;
      m_hi    = b;
    end else begin
      p.d   = {m_hi, b};
      p.idx = m_idx;
      p.x   = m_idx % W;
      p.y   = m_idx / W;
      p.fs  = (m_idx == 0);
      p.fc  = m_frame;
      pq.push_back(p);
      have_hi = 1'b0;
      if (m_idx == NPIX - 1) begin
        m_idx   = 0;
        m_frame = (m_frame + 1) % 256;
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic drive_bit(input logic b, input logic dc, input logic last);
    bus.sdin = b;
    bus.d_cn = dc;
    repeat (3) @(posedge clk);
    #2 bus.sclk = 1'b1;
    if (last) last_rise = cyc;
    repeat (3) @(posedge clk);
    #2 bus.sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    model_byte(b, dc);
    for (int i = 7; i >= 0; i--) drive_bit(b[i], dc, i == 0);
  endtask

  task automatic send_pixel(input logic [15:0] p);
    send_byte(p[15:8], 1'b1);
    send_byte(p[7:0], 1'b1);
  endtask

  task automatic send_partial(input int nbits);
    for (int i = 0; i < nbits; i++) drive_bit(1'b1, 1'b1, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_byte_valid"},  32'(bus.byte_valid),  32'd0);
    chk({tag, "_byte_data"},   32'(bus.byte_data),   32'd0);
    chk({tag, "_byte_is_data"},32'(bus.byte_is_data),32'd0);
    chk({tag, "_pixel_valid"}, 32'(bus.pixel_valid), 32'd0);
    chk({tag, "_pixel_data"},  32'(bus.pixel_data),  32'd0);
    chk({tag, "_pixel_index"}, 32'(bus.pixel_index), 32'd0);
    chk({tag, "_pixel_x"},     32'(bus.pixel_x),     32'd0);
    chk({tag, "_pixel_y"},     32'(bus.pixel_y),     32'd0);
    chk({tag, "_frame_start"}, 32'(bus.frame_start), 32'd0);
    chk({tag, "_frame_count"}, 32'(bus.frame_count), 32'd0);
    chk({tag, "_panel_on"},    32'(bus.panel_on),    32'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a byte or pixel.
  always @(negedge clk) begin
    exp_byte_t eb;
    exp_pix_t  ep;
    if (reset) begin
      if (bus.byte_valid) begin
        chk("byte_pulse_width", 32'(prev_bv), 32'd0);
        chk("byte_latency", 32'(cyc - last_rise), 32'(S + 2));
        chk("byte_expected", 32'(bq.size() > 0), 32'd1);
        if (bq.size() > 0) begin
          eb = bq.pop_front();
          chk("byte_data", 32'(bus.byte_data), 32'(eb.d));
          chk("byte_is_data", 32'(bus.byte_is_data), 32'(eb.dc));
        end
      end
      if (bus.pixel_valid) begin
        chk("pixel_with_byte", 32'(bus.byte_valid), 32'd1);
        chk("pixel_expected", 32'(pq.size() > 0), 32'd1);
        if (pq.size() > 0) begin
          ep = pq.pop_front();
          chk("pixel_data",  32'(bus.pixel_data),  32'(ep.d));
          chk("pixel_index", 32'(bus.pixel_index), 32'(ep.idx));
          chk("pixel_x",     32'(bus.pixel_x),     32'(ep.x));
          chk("pixel_y",     32'(bus.pixel_y),     32'(ep.y));
          chk("frame_start", 32'(bus.frame_start), 32'(ep.fs));
          chk("frame_count", 32'(bus.frame_count), 32'(ep.fc));
        end
      end else begin
        chk("frame_start_idle", 32'(bus.frame_start), 32'd0);
      end
    end
    prev_bv = bus.byte_valid;
  end

  initial begin
    bus.cs = 1'b1; bus.sdin = 1'b0; bus.sclk = 1'b0; bus.d_cn = 1'b0;
    bus.resn = 1'b0; bus.vccen = 1'b0; bus.pmoden = 1'b0;
    have_hi = 1'b0; m_hi = 8'h00; m_idx = 0; m_frame = 0; prev_bv = 1'b0;

    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    @(posedge clk);
    #2 reset = 1'b1;

    // panel_on needs all three enables
    bus.resn = 1'b1; bus.vccen = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("panel_on_partial", 32'(bus.panel_on), 32'd0);
    @(posedge clk);
    #2 bus.pmoden = 1'b1;
    repeat (S + 1) @(posedge clk);
    #1 chk("panel_on_rise", 32'(bus.panel_on), 32'd1);

    @(posedge clk);
    #2 bus.cs = 1'b0;
    repeat (4) @(posedge clk);

    // command then one red pixel
    send_byte(8'hA0, 1'b0);
    send_byte(8'hF8, 1'b1);
    send_byte(8'h00, 1'b1);

    // row wrap
    send_byte(8'h15, 1'b0);
    for (int i = 0; i < W + 1; i++) send_pixel(16'h07E0);

    // full frame wrap, distinct data per pixel
    send_byte(8'h15, 1'b0);
    for (int i = 0; i < NPIX + 1; i++) send_pixel(16'(16'h0100 + i));

    // cs abort discards a partial byte
    send_partial(5);
    @(posedge clk);
    #2 bus.cs = 1'b1;
    repeat (10) @(posedge clk);
    #2 bus.cs = 1'b0;
    repeat (4) @(posedge clk);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);

    // command in the middle of a pixel
    send_byte(8'hAB, 1'b1);
    send_byte(8'h15, 1'b0);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);

    // async reset mid-stream with a partial byte in flight
    send_pixel(16'h1111);
    send_pixel(16'h2222);
    send_pixel(16'h3333);
    send_partial(3);
    #1 chk("panel_on_before_reset", 32'(bus.panel_on), 32'd1);
    chk("frame_count_before_reset", 32'(bus.frame_count), 32'(m_frame));
    chk("pixel_index_before_reset", 32'(bus.pixel_index), 32'(m_idx));
    @(posedge clk);
    #3 reset = 1'b0;
    #1 chk_all_zero("async_reset");
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    have_hi = 1'b0; m_idx = 0; m_frame = 0;
    repeat (S + 1) @(posedge clk);
    #1 chk("panel_on_after_reset", 32'(bus.panel_on), 32'd1);
    repeat (2) @(posedge clk);
    send_pixel(16'h001F);

    repeat (40) @(posedge clk);
    chk("bytes_outstanding", 32'(bq.size()), 32'd0);
    chk("pixels_outstanding", 32'(pq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
